reg_cmd_engine: RTL and testbench



---
 rtl/reg_cmd_pkg.sv | 21 ++
 rtl/reg_cmd_engine_if.sv | 30 +++
 rtl/reg_cmd_engine.sv | 172 +++++++++++++++++
 tb/tb_reg_cmd_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_pkg.sv
// Shared command codes and FSM state encoding for the register command engine.
package reg_cmd_pkg;

    typedef enum logic [7:0] {
        CMD_NOP = 8'h00,
        CMD_WR  = 8'h01,
        CMD_RD  = 8'h02
    } cmd_t;

    typedef enum logic [2:0] {
        S_CMD,
        S_LEN,
        S_ADDR,
        S_WDATA,
        S_RD_REQ,
        S_RD_WAIT,
        S_TX_LOAD,
        S_TX_WAIT
    } state_t;

endpackage

// File: rtl/reg_cmd_engine_if.sv
// UART byte streams plus register-bank bus seen by the command engine.
interface reg_cmd_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              rx_done_i;
    logic [7:0]        rx_data_i;
    logic              tx_done_i;
    logic              tx_start_o;
    logic [7:0]        tx_data_o;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [DATA_W-1:0] reg_wdata_o;
    logic              wr_en_o;
    logic              rd_en_o;
    logic [DATA_W-1:0] rd_data_i;
    logic              busy_o;
    logic              err_o;

    modport slave (
        input  rx_done_i, rx_data_i, tx_done_i, rd_data_i,
        output tx_start_o, tx_data_o, reg_addr_o, reg_wdata_o,
        output wr_en_o, rd_en_o, busy_o, err_o
    );

    modport master (
        output rx_done_i, rx_data_i, tx_done_i, rd_data_i,
        input  tx_start_o, tx_data_o, reg_addr_o, reg_wdata_o,
        input  wr_en_o, rd_en_o, busy_o, err_o
    );
endinterface

// File: rtl/reg_cmd_engine.sv
// Framed UART command parser: burst register writes/reads with MSB-first
// multi-byte address/data, read data serialised back to the UART TX.
module reg_cmd_engine
    import reg_cmd_pkg::*;
#(
    parameter int ADDR_BYTES  = 1,
    parameter int DATA_BYTES  = 1,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic            clk,
    input  logic            rst,
    reg_cmd_engine_if.slave bus
);
    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int MAXB   = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int BW     = $clog2(MAXB + 1);
    localparam int LW     = $clog2(RD_LAT + 1);
    localparam int TOW    = $clog2(TIMEOUT_CYC + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [8:0]        words_q, words_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [TOW-1:0]    idle_q, idle_d;
    logic              wr_q, wr_d;
    logic              is_rd_q, is_rd_d;
    logic              to_hit, bad_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CMD;
            addr_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            tx_sh_q <= '0;
            byte_q  <= '0;
            words_q <= '0;
            lat_q   <= '0;
            idle_q  <= '0;
            wr_q    <= 1'b0;
            is_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            tx_sh_q <= tx_sh_d;
            byte_q  <= byte_d;
            words_q <= words_d;
            lat_q   <= lat_d;
            idle_q  <= idle_d;
            wr_q    <= wr_d;
            is_rd_q <= is_rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        tx_sh_d = tx_sh_q;
        byte_d  = byte_q;
        words_d = words_q;
        lat_d   = lat_q;
        idle_d  = '0;
        wr_d    = 1'b0;
        is_rd_d = is_rd_q;
        to_hit  = 1'b0;
        bad_cmd = 1'b0;

        // Post-write increment lands the cycle the strobe is visible.
        if (wr_q) addr_d = addr_q + 1'b1;

        // A byte arriving on the expiry cycle wins over the timeout.
        if (state_q inside {S_LEN, S_ADDR, S_WDATA}) begin
            if (bus.rx_done_i) begin
                idle_d = '0;
            end else if (idle_q == TOW'(TIMEOUT_CYC - 1)) begin
                to_hit  = 1'b1;
                state_d = S_CMD;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        case (state_q)
            S_CMD: if (bus.rx_done_i) begin
                byte_d = '0;
                case (cmd_t'(bus.rx_data_i))
                    CMD_NOP: ;
                    CMD_WR:  begin is_rd_d = 1'b0; state_d = S_LEN; end
                    CMD_RD:  begin is_rd_d = 1'b1; state_d = S_LEN; end
                    default: bad_cmd = 1'b1;
                endcase
            end
            S_LEN: if (bus.rx_done_i) begin
                words_d = (bus.rx_data_i == 8'h00) ? 9'd256 : {1'b0, bus.rx_data_i};
                byte_d  = '0;
                state_d = S_ADDR;
            end
            S_ADDR: if (bus.rx_done_i) begin
                addr_d = ADDR_W'({addr_q, bus.rx_data_i});
                if (byte_q == BW'(ADDR_BYTES - 1)) begin
                    byte_d  = '0;
                    state_d = is_rd_q ? S_RD_REQ : S_WDATA;
                end else begin
                    byte_d = byte_q + 1'b1;
                end
            end
            S_WDATA: if (bus.rx_done_i) begin
                word_d = DATA_W'({word_q, bus.rx_data_i});
                if (byte_q == BW'(DATA_BYTES - 1)) begin
                    wdata_d = DATA_W'({word_q, bus.rx_data_i});
                    wr_d    = 1'b1;
                    byte_d  = '0;
                    words_d = words_q - 9'd1;
                    if (words_q == 9'd1) state_d = S_CMD;
                end else begin
                    byte_d = byte_q + 1'b1;
                end
            end
            S_RD_REQ: begin
                lat_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q == LW'(RD_LAT - 1)) begin
                    tx_sh_d = bus.rd_data_i;
                    byte_d  = '0;
                    state_d = S_TX_LOAD;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_TX_LOAD: state_d = S_TX_WAIT;
            S_TX_WAIT: if (bus.tx_done_i) begin
                tx_sh_d = tx_sh_q << 8;
                if (byte_q != BW'(DATA_BYTES - 1)) begin
                    byte_d  = byte_q + 1'b1;
                    state_d = S_TX_LOAD;
                end else if (words_q != 9'd1) begin
                    words_d = words_q - 9'd1;
                    addr_d  = addr_q + 1'b1;
                    state_d = S_RD_REQ;
                end else begin
                    state_d = S_CMD;
                end
            end
            default: state_d = S_CMD;
        endcase
    end

    // Strobes are masked while reset is held so an abort emits nothing.
    always_comb begin
        bus.busy_o      = (state_q != S_CMD);
        bus.rd_en_o     = !rst && (state_q == S_RD_REQ);
        bus.tx_start_o  = !rst && (state_q == S_TX_LOAD);
        bus.wr_en_o     = !rst && wr_q;
        bus.err_o       = !rst && (to_hit || bad_cmd);
        bus.tx_data_o   = tx_sh_q[DATA_W-1 -: 8];
        bus.reg_addr_o  = addr_q;
        bus.reg_wdata_o = wdata_q;
    end

endmodule

// File: tb/tb_reg_cmd_engine.sv
// Directed bench for reg_cmd_engine: frame table plus reset/timeout/burst sequences.
module tb_reg_cmd_engine;

    typedef struct {
        int          nb;
        logic [55:0] bs;
        int          n_wr, n_rd, n_tx, n_err;
        logic [7:0]  a0, a1;
        logic [15:0] d0, d1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_cmd_engine_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    reg_cmd_engine #(
        .ADDR_BYTES(1), .DATA_BYTES(2), .RD_LAT(1), .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0, err_cnt = 0, err_cyc = 0, tx_viol = 0, tx_cd = 0, last_rx_cyc = 0;
    logic [7:0]  tx_last = '0;
    logic [7:0]  wr_a[$], rd_a[$], txb[$];
    logic [15:0] wr_d[$];
    logic [15:0] mem [0:255];
    bit   [255:0] mem_v;

    function automatic logic [15:0] rd_model(input logic [7:0] a);
        if (mem_v[a]) return mem[a];
        if (a == 8'h20) return 16'hBEEF;
        return {a, ~a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank, UART TX partner and strobe logger.
    always @(negedge clk) begin
        bus.tx_done_i = 1'b0;
        if (rst) begin
            tx_cd = 0;
        end else if (tx_cd > 0) begin
            if (bus.tx_data_o != tx_last) tx_viol++;
            tx_cd--;
            if (tx_cd == 0) bus.tx_done_i = 1'b1;
        end
        if (bus.tx_start_o) begin
            if (tx_cd != 0) tx_viol++;
            tx_last = bus.tx_data_o;
            txb.push_back(bus.tx_data_o);
            tx_cd = 3;
        end
        if (bus.wr_en_o) begin
            wr_a.push_back(bus.reg_addr_o);
            wr_d.push_back(bus.reg_wdata_o);
            mem[bus.reg_addr_o]   = bus.reg_wdata_o;
            mem_v[bus.reg_addr_o] = 1'b1;
        end
        if (bus.rd_en_o) begin
            rd_a.push_back(bus.reg_addr_o);
            bus.rd_data_i = rd_model(bus.reg_addr_o);
        end
        if (bus.err_o) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data_i = b;
        bus.rx_done_i = 1'b1;
        last_rx_cyc   = cyc;
        @(negedge clk);
        bus.rx_done_i = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy_o || tx_cd != 0) && n < 3000);
        repeat (3) @(negedge clk);
        chk("settle_in_time", (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic chk_idle_outs(input string pfx);
        chk({pfx, "_strobes"}, {27'd0, bus.wr_en_o, bus.rd_en_o, bus.tx_start_o,
                                bus.busy_o, bus.err_o}, 32'd0);
        chk({pfx, "_tx_data"}, {24'd0, bus.tx_data_o}, 32'd0);
        chk({pfx, "_addr"}, {24'd0, bus.reg_addr_o}, 32'd0);
        chk({pfx, "_wdata"}, {16'd0, bus.reg_wdata_o}, 32'd0);
    endtask

    task automatic pulse_rst(input string pfx);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_idle_outs(pfx);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    function automatic vec_t mk(input int nb, input logic [55:0] bs,
                                input int nw, input int nr, input int nt, input int ne,
                                input logic [7:0] a0, input logic [15:0] d0,
                                input logic [7:0] a1, input logic [15:0] d1);
        vec_t v;
        v.nb = nb; v.bs = bs;
        v.n_wr = nw; v.n_rd = nr; v.n_tx = nt; v.n_err = ne;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        return v;
    endfunction

    initial begin
        vec_t        vt [6];
        logic [55:0] bs;
        logic [15:0] w;
        int w0, r0, t0, e0, n, errs;

        bus.rx_done_i = 1'b0;
        bus.rx_data_i = 8'h00;

        vt[0] = mk(7, 56'h01_02_10_AB_CD_12_34, 2, 0, 0, 0, 8'h10, 16'hABCD, 8'h11, 16'h1234);
        vt[1] = mk(3, 56'h02_01_20_00_00_00_00, 0, 1, 2, 0, 8'h20, 16'hBEEF, 8'h00, 16'h0000);
        vt[2] = mk(1, 56'h7F_00_00_00_00_00_00, 0, 0, 0, 1, 8'h00, 16'h0000, 8'h00, 16'h0000);
        vt[3] = mk(1, 56'h00_00_00_00_00_00_00, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00, 16'h0000);
        vt[4] = mk(3, 56'h02_02_10_00_00_00_00, 0, 2, 4, 0, 8'h10, 16'hABCD, 8'h11, 16'h1234);
        vt[5] = mk(5, 56'h01_01_05_00_07_00_00, 1, 0, 0, 0, 8'h05, 16'h0007, 8'h00, 16'h0000);

        repeat (3) @(negedge clk);
        chk_idle_outs("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            w0 = wr_a.size(); r0 = rd_a.size(); t0 = txb.size(); e0 = err_cnt;
            bs = vt[i].bs;
            for (int j = 0; j < vt[i].nb; j++) send(bs[55-8*j -: 8]);
            settle();
            chk($sformatf("v%0d_nwr", i), wr_a.size() - w0, vt[i].n_wr);
            chk($sformatf("v%0d_nrd", i), rd_a.size() - r0, vt[i].n_rd);
            chk($sformatf("v%0d_ntx", i), txb.size() - t0, vt[i].n_tx);
            chk($sformatf("v%0d_nerr", i), err_cnt - e0, vt[i].n_err);
            if (vt[i].n_wr >= 1 && wr_a.size() >= w0 + 1) begin
                chk($sformatf("v%0d_wa0", i), wr_a[w0], vt[i].a0);
                chk($sformatf("v%0d_wd0", i), wr_d[w0], vt[i].d0);
            end
            if (vt[i].n_wr >= 2 && wr_a.size() >= w0 + 2) begin
                chk($sformatf("v%0d_wa1", i), wr_a[w0+1], vt[i].a1);
                chk($sformatf("v%0d_wd1", i), wr_d[w0+1], vt[i].d1);
            end
            if (vt[i].n_rd >= 1 && rd_a.size() >= r0 + 1 && txb.size() >= t0 + 2) begin
                chk($sformatf("v%0d_ra0", i), rd_a[r0], vt[i].a0);
                chk($sformatf("v%0d_tx0", i), {txb[t0], txb[t0+1]}, vt[i].d0);
            end
            if (vt[i].n_rd >= 2 && rd_a.size() >= r0 + 2 && txb.size() >= t0 + 4) begin
                chk($sformatf("v%0d_ra1", i), rd_a[r0+1], vt[i].a1);
                chk($sformatf("v%0d_tx1", i), {txb[t0+2], txb[t0+3]}, vt[i].d1);
            end
        end
        chk("tx_handshake", tx_viol, 0);

        // Timeout: frame stalls after LEN, error exactly 50 cycles later.
        w0 = wr_a.size(); e0 = err_cnt;
        send(8'h01); send(8'h01);
        n = 0;
        while (err_cnt == e0 && n < 200) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        chk("to_err_cnt", err_cnt - e0, 1);
        chk("to_delay", err_cyc - last_rx_cyc, 50);
        chk("to_nwr", wr_a.size() - w0, 0);
        chk("to_busy", {31'd0, bus.busy_o}, 0);
        send(8'h01); send(8'h01); send(8'h30); send(8'h11); send(8'h22);
        settle();
        chk("post_to_nwr", wr_a.size() - w0, 1);
        if (wr_a.size() == w0 + 1) begin
            chk("post_to_addr", wr_a[w0], 8'h30);
            chk("post_to_data", wr_d[w0], 16'h1122);
        end

        // Byte landing on the expiry cycle keeps the frame alive.
        w0 = wr_a.size(); e0 = err_cnt;
        send(8'h01); send(8'h01);
        while (cyc < last_rx_cyc + 49) @(negedge clk);
        send(8'h60); send(8'h12); send(8'h34);
        settle();
        chk("to_edge_err", err_cnt - e0, 0);
        chk("to_edge_nwr", wr_a.size() - w0, 1);
        if (wr_a.size() == w0 + 1) chk("to_edge_word", {wr_a[w0], wr_d[w0]}, 32'h60_1234);

        // Reset in the middle of the second write word.
        w0 = wr_a.size(); e0 = err_cnt;
        send(8'h01); send(8'h02); send(8'h40); send(8'hAA); send(8'hBB); send(8'hCC);
        pulse_rst("rst_wd");
        repeat (60) @(negedge clk);
        chk("rst_wd_nwr", wr_a.size() - w0, 1);
        chk("rst_wd_err", err_cnt - e0, 0);
        send(8'h01); send(8'h01); send(8'h41); send(8'h55); send(8'h66);
        settle();
        chk("rst_wd_after_nwr", wr_a.size() - w0, 2);
        if (wr_a.size() == w0 + 2) begin
            chk("rst_wd_word0", {wr_a[w0], wr_d[w0]}, 32'h40_AABB);
            chk("rst_wd_word1", {wr_a[w0+1], wr_d[w0+1]}, 32'h41_5566);
        end

        // Reset while waiting for the first TX byte to finish.
        r0 = rd_a.size(); t0 = txb.size(); e0 = err_cnt;
        send(8'h02); send(8'h01); send(8'h50);
        n = 0;
        while (txb.size() == t0 && n < 200) begin @(negedge clk); n++; end
        chk("rst_tx_started", txb.size() - t0, 1);
        pulse_rst("rst_tx");
        repeat (30) @(negedge clk);
        chk("rst_tx_ntx", txb.size() - t0, 1);
        chk("rst_tx_nrd", rd_a.size() - r0, 1);
        if (txb.size() >= t0 + 1) chk("rst_tx_b0", txb[t0], 8'h50);
        send(8'h02); send(8'h01); send(8'h20);
        settle();
        chk("rst_tx_after_ntx", txb.size() - t0, 3);
        if (txb.size() == t0 + 3) chk("rst_tx_after_word", {txb[t0+1], txb[t0+2]}, 16'hBEEF);
        chk("rst_tx_err", err_cnt - e0, 0);

        // LEN=0 burst from 0xFF: 256 words, address wraps.
        w0 = wr_a.size();
        send(8'h01); send(8'h00); send(8'hFF);
        for (int k = 0; k < 256; k++) begin
            w = {8'(k) ^ 8'h5A, 8'(k)};
            send(w[15:8]);
            send(w[7:0]);
        end
        settle();
        chk("burst_nwr", wr_a.size() - w0, 256);
        if (wr_a.size() == w0 + 256) begin
            errs = 0;
            for (int k = 0; k < 256; k++) begin
                w = {8'(k) ^ 8'h5A, 8'(k)};
                if (wr_a[w0+k] != 8'(8'hFF + k) || wr_d[w0+k] != w) errs++;
            end
            chk("burst_seq_errs", errs, 0);
            chk("burst_a_first", wr_a[w0], 8'hFF);
            chk("burst_a_wrap", wr_a[w0+1], 8'h00);
            chk("burst_a_last", wr_a[w0+255], 8'hFE);
        end
        chk("final_busy", {31'd0, bus.busy_o}, 0);
        chk("final_tx_handshake", tx_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
